count_ctrl_arb: RTL and testbench
=================================

Name: count_ctrl_arb

Overview:
Controller and round-robin arbiter that shares one mod-12 loadable up/down counter between two requesters. Each requester issues commands over a valid/ready handshake: LOAD, run UP to a target, run DOWN to a target, or READ. The block owns the counter's load/mode/data_in pins and holds the counter (self-reload) whenever no command is running. It sits directly in front of the counter instance, alongside the counter's interface.

Parameters:
MOD, 12, counter modulus; legal values are 0..MOD-1.
W, 4, width of counter value, data_in and data_out.

Ports:
clock  input  1  single clock, posedge.
reset  input  1  asynchronous, active-high; also drives the counter's reset.
req0_valid  input  1  requester 0 command valid.
req0_ready  output  1  requester 0 command accepted this cycle.
req0_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 READ.
req0_val  input  W  load value / target (ignored for READ).
req1_valid, req1_ready, req1_op, req1_val  same as req0, for requester 1.
done0  output  1  one-cycle completion pulse to requester 0.
done1  output  1  one-cycle completion pulse to requester 1.
rsp_data  output  W  counter value at completion; valid while done0/done1 is high.
rsp_err  output  1  command rejected; valid while done0/done1 is high.
cnt_load  output  1  to counter load.
cnt_mode  output  1  to counter mode (1 = up, 0 = down).
cnt_data_in  output  W  to counter data_in.
cnt_data_out  input  W  from counter data_out.
busy  output  1  high when state is not IDLE.
chk_err  output  1  sticky shadow-mismatch flag (see Optional Feature).

Behaviour:
- Counter contract (mod-12):
  - load has priority over counting.
  - mode 1 counts up with wrap 11->0; mode 0 counts down with wrap 0->11.
  - data_out updates at posedge.
  - reset clears the count to 0.
- Shadow register shadow_q (W bits) tracks the committed counter value; it resets to 0.
- All outputs are registered except reqN_ready.
- Reset values:
  - state=IDLE, cnt_load=1, cnt_mode=1, cnt_data_in=0.
  - done0/1=0, rsp_data=0, rsp_err=0, busy=0, chk_err=0.
  - last-grant pointer=1, so req0 wins the first contention.
- States: IDLE, LOAD, RUN, RESP.
- IDLE:
  - Holds the counter: cnt_load=1, cnt_data_in=shadow_q.
  - Arbitration:
    - If only one requester is valid, it is granted.
    - If both are valid, the requester not granted last is chosen.
  - reqN_ready=1 only for the granted requester, and only in IDLE; ready is combinational from state and valid.
  - Accept = valid & ready at cycle T. Op and val are latched together with the owner id.
- Rejection: LOAD/UP/DOWN with val > MOD-1 -> RESP at T+1 with rsp_err=1 and rsp_data=shadow_q; the counter is untouched.
- LOAD:
  - T+1: cnt_load=1, cnt_data_in=val.
  - T+2: RESP with rsp_data=val; shadow_q=val.
- UP/DOWN:
  - At accept, steps = (val - shadow_q) mod MOD for UP, or (shadow_q - val) mod MOD for DOWN.
  - RUN lasts exactly `steps` cycles (T+1..T+steps) with cnt_load=0 and cnt_mode=1 (UP) / 0 (DOWN).
  - RESP follows at T+steps+1: counter held at val, rsp_data=val, shadow_q=val.
  - steps=0 -> skip RUN; RESP at T+1.
- READ: RESP at T+1 with rsp_data=shadow_q; no counter motion.
- RESP:
  - doneN=1 for the owner only, for one cycle; the counter is held at the new shadow value.
  - Next state is IDLE; no new accept is possible in the RESP cycle.
  - The earliest back-to-back accept is therefore 1 cycle after RESP.
- Requests are not preempted. A requester may drop valid before ready with no effect.
- Asynchronous reset mid-operation: immediate return to IDLE with the reset values above; no done is issued for the in-flight command.

Optional Feature:
Macro COUNT_CTRL_CHECK_EN.
- Defined:
  - In IDLE and RESP, compare cnt_data_out with the expected value each cycle; the expected value is shadow_q.
  - On mismatch set chk_err=1, which stays set until reset.
  - The check is disabled during the cycle after reset deassertion.
- Undefined: no comparator is built; chk_err is tied to 0.

Test Plan:
- Reset, then req0 LOAD 7 at T -> cnt_load=1 and cnt_data_in=7 at T+1; done0=1, rsp_data=7, rsp_err=0 at T+2; cnt_data_out stays 7 afterwards.
- From 7, req1 UP 2 -> steps=7, RUN cycles T+1..T+7 with cnt_mode=1; counter passes 11->0 wrap; done1 at T+8 with rsp_data=2.
- From 2, req0 DOWN 10 -> steps=4 (2,1,0,11,10); done0 at T+5 with rsp_data=10. Then DOWN 10 again -> steps=0, done0 at T+1.
- req0 LOAD 13 -> done0 at T+1 with rsp_err=1 and rsp_data=previous value; cnt_data_out unchanged.
- Both valid continuously with READs -> grants alternate req0, req1, req0...; each done goes only to its owner; rsp_data equals the current count.
- Assert reset during UP RUN at steps 3/6 -> all outputs return to reset values asynchronously; no done; cnt_data_out=0. With COUNT_CTRL_CHECK_EN, force cnt_data_out≠shadow in IDLE -> chk_err=1 and stays set until reset.

Source files
------------

// File: rtl/count_ctrl_arb.sv
// Round-robin controller sharing one mod-MOD counter between two requesters; optional shadow checker under COUNT_CTRL_CHECK_EN.
// Latency: LOAD 2 cycles, UP/DOWN steps+1, READ/reject 1; reqN_ready only in IDLE, so a held valid simply waits.
module count_ctrl_arb #(
    parameter int MOD = 12,
    parameter int W   = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [W-1:0] req0_val,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [W-1:0] req1_val,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err,
    output logic         cnt_load,
    output logic         cnt_mode,
    output logic [W-1:0] cnt_data_in,
    input  logic [W-1:0] cnt_data_out,
    output logic         busy,
    output logic         chk_err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESP} state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    state_t         r_state;
    logic           r_owner;
    logic [1:0]     r_op;
    logic [W-1:0]   r_val;
    logic [W-1:0]   r_steps;
    logic [W-1:0]   r_shadow;
    logic           r_last;
    logic           r_done0;
    logic           r_done1;
    logic [W-1:0]   r_rsp_data;
    logic           r_rsp_err;
    logic           r_cnt_load;
    logic           r_cnt_mode;
    logic [W-1:0]   r_cnt_data_in;
    logic           r_busy;

    state_t         w_state_nxt;
    logic [W-1:0]   w_steps_nxt;
    logic [W-1:0]   w_shadow_nxt;
    logic           w_done0_nxt;
    logic           w_done1_nxt;
    logic [W-1:0]   w_rsp_data_nxt;
    logic           w_rsp_err_nxt;
    logic           w_cnt_load_nxt;
    logic           w_cnt_mode_nxt;
    logic [W-1:0]   w_cnt_data_in_nxt;
    logic           w_done_id;

    logic           w_idle;
    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_acc;
    logic           w_acc_id;
    logic [1:0]     w_acc_op;
    logic [W-1:0]   w_acc_val;
    logic           w_bad;
    logic [W:0]     w_a;
    logic [W:0]     w_s;
    logic [W:0]     w_up_wide;
    logic [W:0]     w_dn_wide;
    logic [W-1:0]   w_steps;

    // Tie-break favours whichever requester was not granted last.
    assign w_idle     = (r_state == S_IDLE);
    assign w_gnt0     = w_idle & req0_valid & (~req1_valid | r_last);
    assign w_gnt1     = w_idle & req1_valid & (~req0_valid | ~r_last);
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign w_acc      = w_gnt0 | w_gnt1;
    assign w_acc_id   = w_gnt1;
    assign w_acc_op   = w_gnt1 ? req1_op  : req0_op;
    assign w_acc_val  = w_gnt1 ? req1_val : req0_val;
    assign w_bad      = (w_acc_op != OP_READ) && (w_acc_val > W'(MOD - 1));

    assign w_a = {1'b0, w_acc_val};
    assign w_s = {1'b0, r_shadow};

    // Modular distance to the target; only meaningful when the target is legal.
    always_comb begin
        w_up_wide = w_a - w_s;
        w_dn_wide = w_s - w_a;
        if (w_a < w_s) begin
            w_up_wide = w_a + (W+1)'(MOD) - w_s;
        end
        if (w_s < w_a) begin
            w_dn_wide = w_s + (W+1)'(MOD) - w_a;
        end
    end

    assign w_steps   = (w_acc_op == OP_UP) ? w_up_wide[W-1:0] : w_dn_wide[W-1:0];
    assign w_done_id = w_idle ? w_acc_id : r_owner;

    always_comb begin
        w_state_nxt       = r_state;
        w_steps_nxt       = r_steps;
        w_shadow_nxt      = r_shadow;
        w_done0_nxt       = 1'b0;
        w_done1_nxt       = 1'b0;
        w_rsp_data_nxt    = r_rsp_data;
        w_rsp_err_nxt     = 1'b0;
        w_cnt_load_nxt    = 1'b1;
        w_cnt_mode_nxt    = r_cnt_mode;
        w_cnt_data_in_nxt = r_shadow;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (w_bad) begin
                        w_state_nxt    = S_RESP;
                        w_rsp_data_nxt = r_shadow;
                        w_rsp_err_nxt  = 1'b1;
                    end else if (w_acc_op == OP_LOAD) begin
                        w_state_nxt       = S_LOAD;
                        w_cnt_data_in_nxt = w_acc_val;
                    end else if (w_acc_op == OP_READ) begin
                        w_state_nxt    = S_RESP;
                        w_rsp_data_nxt = r_shadow;
                    end else if (w_steps == '0) begin
                        w_state_nxt    = S_RESP;
                        w_rsp_data_nxt = w_acc_val;
                        w_shadow_nxt   = w_acc_val;
                    end else begin
                        w_state_nxt    = S_RUN;
                        w_steps_nxt    = w_steps;
                        w_cnt_load_nxt = 1'b0;
                        w_cnt_mode_nxt = (w_acc_op == OP_UP);
                    end
                end
            end
            S_LOAD: begin
                w_state_nxt       = S_RESP;
                w_shadow_nxt      = r_val;
                w_cnt_data_in_nxt = r_val;
                w_rsp_data_nxt    = r_val;
            end
            S_RUN: begin
                if (r_steps == W'(1)) begin
                    w_state_nxt       = S_RESP;
                    w_shadow_nxt      = r_val;
                    w_cnt_data_in_nxt = r_val;
                    w_rsp_data_nxt    = r_val;
                end else begin
                    w_steps_nxt    = r_steps - W'(1);
                    w_cnt_load_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_state_nxt == S_RESP) begin
            w_done0_nxt = ~w_done_id;
            w_done1_nxt = w_done_id;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_owner       <= 1'b0;
            r_op          <= OP_LOAD;
            r_val         <= '0;
            r_steps       <= '0;
            r_shadow      <= '0;
            r_last        <= 1'b1;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
            r_cnt_load    <= 1'b1;
            r_cnt_mode    <= 1'b1;
            r_cnt_data_in <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_steps       <= w_steps_nxt;
            r_shadow      <= w_shadow_nxt;
            r_done0       <= w_done0_nxt;
            r_done1       <= w_done1_nxt;
            r_rsp_data    <= w_rsp_data_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_cnt_load    <= w_cnt_load_nxt;
            r_cnt_mode    <= w_cnt_mode_nxt;
            r_cnt_data_in <= w_cnt_data_in_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
            if (w_acc) begin
                r_owner <= w_acc_id;
                r_op    <= w_acc_op;
                r_val   <= w_acc_val;
                r_last  <= w_acc_id;
            end
        end
    end

    assign done0       = r_done0;
    assign done1       = r_done1;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;
    assign cnt_load    = r_cnt_load;
    assign cnt_mode    = r_cnt_mode;
    assign cnt_data_in = r_cnt_data_in;
    assign busy        = r_busy;

`ifdef COUNT_CTRL_CHECK_EN
    logic r_chk_arm;
    logic r_chk_err;

    // Arm one cycle after reset release so the counter has settled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_chk_arm <= 1'b0;
            r_chk_err <= 1'b0;
        end else begin
            r_chk_arm <= 1'b1;
            if (r_chk_arm && (r_state == S_IDLE || r_state == S_RESP) &&
                (cnt_data_out != r_shadow)) begin
                r_chk_err <= 1'b1;
            end
        end
    end

    assign chk_err = r_chk_err;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = ^{cnt_data_out, r_op};
    assign chk_err      = 1'b0;
`endif

endmodule

// File: tb/tb_count_ctrl_arb.sv
// Scoreboard bench for count_ctrl_arb with a behavioural mod-12 counter attached to the control pins.
module tb_count_ctrl_arb;
    localparam int MOD = 12;
    localparam int W   = 4;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;
`ifdef COUNT_CTRL_CHECK_EN
    localparam int CHK_EN = 1;
`else
    localparam int CHK_EN = 0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_op = 2'b00, req1_op = 2'b00;
    logic [W-1:0] req0_val = '0, req1_val = '0;
    logic         done0, done1, rsp_err, cnt_load, cnt_mode, busy, chk_err;
    logic [W-1:0] rsp_data, cnt_data_in, cnt_data_out;
    logic [W-1:0] cnt_q;
    logic         corrupt = 1'b0;

    always #5 clock = ~clock;

    count_ctrl_arb #(.MOD(MOD), .W(W)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_val(req0_val),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_val(req1_val),
        .done0(done0), .done1(done1), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cnt_load(cnt_load), .cnt_mode(cnt_mode), .cnt_data_in(cnt_data_in),
        .cnt_data_out(cnt_data_out), .busy(busy), .chk_err(chk_err)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                    cnt_q <= '0;
        else if (cnt_load)            cnt_q <= cnt_data_in;
        else if (cnt_mode)            cnt_q <= (cnt_q == W'(MOD - 1)) ? '0 : cnt_q + W'(1);
        else                          cnt_q <= (cnt_q == '0) ? W'(MOD - 1) : cnt_q - W'(1);
    end
    assign cnt_data_out = corrupt ? (cnt_q ^ W'(1)) : cnt_q;

    typedef struct {
        int owner;
        int data;
        int err;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m_shadow = 0;
    int   m_last = 1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: completion is k cycles after the accept, k from the command rules.
    task automatic predict(input int port, input int op, input int v, input int tpos, output int steps, output int err);
        exp_t e;
        int k;
        steps = 0;
        err = 0;
        e.owner = port;
        if (op != OP_READ && v >= MOD) begin
            err = 1; e.data = m_shadow; k = 1;
        end else if (op == OP_LOAD) begin
            e.data = v; k = 2; m_shadow = v;
        end else if (op == OP_READ) begin
            e.data = m_shadow; k = 1;
        end else begin
            steps = (op == OP_UP) ? (v - m_shadow + MOD) % MOD : (m_shadow - v + MOD) % MOD;
            e.data = v; k = steps + 1; m_shadow = v;
        end
        e.err = err;
        e.cyc = tpos + k - 1;
        sbq.push_back(e);
        m_last = port;
    endtask

    always @(negedge clock) begin
        if (!reset && (done0 || done1)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", {30'd0, done1, done0}, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done_owner", {30'd0, done1, done0}, (e.owner != 0) ? 2 : 1);
                chk("rsp_data", int'(rsp_data), e.data);
                chk("rsp_err", int'(rsp_err), e.err);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("done_timeout", sbq.size(), 0);
            sbq.delete();
        end
        @(negedge clock);
        #2;
        chk("busy_idle", int'(busy), 0);
        chk("cnt_hold", int'(cnt_data_out), m_shadow);
    endtask

    task automatic issue(input int port, input logic [1:0] op, input logic [W-1:0] v, input bit wait_done);
        int n = 0;
        bit got = 0;
        int steps, err;
        @(negedge clock);
        if (port != 0) begin req1_op = op; req1_val = v; req1_valid = 1'b1; end
        else           begin req0_op = op; req0_val = v; req0_valid = 1'b1; end
        while (!got && n < 200) begin
            #1;
            if ((port != 0) ? req1_ready : req0_ready) got = 1;
            else begin @(negedge clock); n++; end
        end
        if (!got) begin
            chk("ready_timeout", 0, 1);
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        predict(port, int'(op), int'(v), cyc + 1, steps, err);
        @(posedge clock);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clock);
        if (err == 0 && op == OP_LOAD) begin
            chk("load_pin", int'(cnt_load), 1);
            chk("load_data", int'(cnt_data_in), int'(v));
        end else if (err == 0 && (op == OP_UP || op == OP_DOWN) && steps > 0) begin
            chk("run_load", int'(cnt_load), 0);
            chk("run_mode", int'(cnt_mode), (op == OP_UP) ? 1 : 0);
        end
        if (wait_done) wait_idle();
    endtask

    task automatic readboth(input int n_acc);
        int acc = 0;
        int n = 0;
        int steps, err;
        @(negedge clock);
        req0_op = OP_READ; req1_op = OP_READ;
        req0_valid = 1'b1; req1_valid = 1'b1;
        while (acc < n_acc && n < 200) begin
            #1;
            if (req0_ready || req1_ready) begin
                chk("grant", req1_ready ? 1 : 0, (m_last != 0) ? 0 : 1);
                chk("ready_onehot", int'(req0_ready & req1_ready), 0);
                predict(req1_ready ? 1 : 0, OP_READ, 0, cyc + 1, steps, err);
                acc++;
            end
            @(negedge clock);
            n++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (acc < n_acc) chk("contention_timeout", acc, n_acc);
        wait_idle();
    endtask

    task automatic check_reset_vals();
        chk("rst_load", int'(cnt_load), 1);
        chk("rst_mode", int'(cnt_mode), 1);
        chk("rst_data_in", int'(cnt_data_in), 0);
        chk("rst_done", {30'd0, done1, done0}, 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_chk_err", int'(chk_err), 0);
        chk("rst_cnt", int'(cnt_data_out), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        check_reset_vals();
        #2 reset = 1'b0;

        issue(0, OP_LOAD, 4'd7, 1);
        issue(1, OP_UP, 4'd2, 1);
        issue(0, OP_DOWN, 4'd10, 1);
        issue(0, OP_DOWN, 4'd10, 1);
        issue(0, OP_LOAD, 4'd13, 1);
        readboth(6);

        for (int i = 0; i < 40; i++) begin
            issue(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), W'($urandom_range(0, 15)), 1);
        end

        @(negedge clock);
        corrupt = 1'b1;
        @(negedge clock);
        corrupt = 1'b0;
        #2;
        chk("chk_err_set", int'(chk_err), CHK_EN);
        repeat (3) @(negedge clock);
        chk("chk_err_sticky", int'(chk_err), CHK_EN);

        issue(0, OP_LOAD, 4'd1, 1);
        issue(1, OP_UP, 4'd0, 0);
        repeat (3) @(negedge clock);
        chk("busy_midrun", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check_reset_vals();
        sbq.delete();
        m_shadow = 0;
        m_last = 1;
        @(negedge clock);
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("post_rst_busy", int'(busy), 0);

        readboth(4);
        issue(1, OP_DOWN, 4'd9, 1);
        chk("final_chk_err", int'(chk_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
